mac_feeder: RTL and testbench
=============================

MAC_FEEDER -- requirements
Module: mac_feeder

Interface
REQ-001 The block SHALL have these parameters, one per line: name, default, meaning.
- INW, 16, operand width in bits.
- OUTW, 48, accumulator/result width in bits.
- K, 8, vector length in elements; legal range 1..2**ADDRW.
- ADDRW, 3, operand memory address width in bits.

REQ-002 The block SHALL have these ports, one per line: name, direction, width, meaning.
- clk, in, 1, the single clock; all state changes on its rising edge.
- reset, in, 1, asynchronous active-high reset.
- start, in, 1, job request.
- ready, out, 1, block is idle and can accept a job.
- rd_en, out, 1, operand memory read enable.
- rd_addr, out, ADDRW, address shared by both operand memories.
- rd_data_a, in, INW signed, memory A read data; valid 1 cycle after rd_en.
- rd_data_b, in, INW signed, memory B read data; valid 1 cycle after rd_en.
- mac_in0, out, INW signed, MAC operand 0.
- mac_in1, out, INW signed, MAC operand 1.
- mac_valid, out, 1, MAC valid_input.
- mac_clear, out, 1, MAC clear_acc.
- mac_out, in, OUTW signed, MAC registered accumulator output.
- result, out, OUTW signed, captured dot product.
- result_valid, out, 1, result is held for the consumer.
- result_ready, in, 1, consumer accepts result.

REQ-003 clk SHALL be the only clock, and reset SHALL be asynchronous and active-high.

Function
REQ-004 The FSM SHALL have the states IDLE, CLEAR, STREAM, WAIT and OUT.
REQ-005 ready SHALL be 1 only in IDLE, and IDLE SHALL move to CLEAR on an edge where start=1.
REQ-006 start SHALL be ignored in every state other than IDLE; the request is not queued.
REQ-007 CLEAR SHALL last exactly 1 cycle with mac_clear=1, mac_valid=0, rd_en=1 and rd_addr=0.
REQ-008 STREAM SHALL last exactly K cycles, with element index i = 0..K-1 held in an internal counter.
REQ-009 In STREAM cycle i, the outputs SHALL be:
- mac_in0=rd_data_a and mac_in1=rd_data_b (combinational pass-through);
- mac_valid=1 and mac_clear=0;
- rd_en=1 and rd_addr=i+1 for i<K-1;
- rd_en=0 for i=K-1.
REQ-010 WAIT SHALL last 1 cycle with mac_valid=0, and result SHALL load mac_out at the end of WAIT.
REQ-011 In OUT, result_valid SHALL be 1 and result SHALL hold stable until an edge where result_ready=1, which returns the FSM to IDLE.
REQ-012 If result_ready is already 1 on entry to OUT, OUT SHALL last exactly 1 cycle.
REQ-013 result_valid SHALL rise exactly K+3 cycles after the cycle in which start was accepted.
REQ-014 Back-to-back jobs SHALL be supported: a start accepted in the IDLE cycle right after OUT begins a new job, and no idle gap beyond that cycle is required.
REQ-015 Outside STREAM, mac_in0, mac_in1 and mac_valid SHALL be 0; mac_clear SHALL be 0 outside CLEAR; rd_en SHALL be 0 outside CLEAR and STREAM.
REQ-016 When not driven per REQ-007/REQ-009, rd_addr SHALL be 0.
REQ-017 The block SHALL do no arithmetic on operands; saturation is owned by the MAC, and result is mac_out bit-exact.
REQ-018 For K=1, STREAM SHALL last 1 cycle with rd_en=0 in that cycle.
REQ-019 The index counter SHALL NOT wrap past K-1 within a job and SHALL be 0 at every entry to STREAM.
REQ-020 result SHALL keep the previous job's value until the next WAIT capture.

Reset
REQ-021 On reset=1, the block SHALL immediately, without waiting for clk, enter IDLE and drive:
- ready=1;
- result=0 and result_valid=0;
- rd_en=0 and rd_addr=0;
- mac_in0=0, mac_in1=0, mac_valid=0 and mac_clear=0;
- index counter=0.
REQ-022 A reset during any state SHALL abort the job with no result produced; the next accepted job's CLEAR clears the MAC.
REQ-023 start sampled on the first edge after reset deasserts SHALL be honoured.

Verification
REQ-024 The bench SHALL cover these directed scenarios:
- K=4, A=[1,2,3,4], B=[5,6,7,8], result_ready=1 -> mac_valid high 4 cycles, result=70 with result_valid on cycle 7 after accept, 1 cycle wide.
- K=4, A=[-3,0,2,-1], B=[4,9,-5,-6], result_ready=0 for 5 OUT cycles -> result=-16 stable all 5 cycles, ready=0 until handshake.
- start pulsed in STREAM and in OUT -> no second CLEAR, exactly one result per accepted start.
- Two back-to-back jobs (A=B=all 1s, then A=all 2s, B=all 3s, K=8) -> results 8 then 48; mac_clear precedes each STREAM.
- reset asserted mid-STREAM (i=2) -> all outputs zero and ready=1 before the next edge; subsequent job gives the correct result.
- K=1, A=[-32768], B=[-32768] -> rd_en high only in CLEAR, result=1073741824.

Source files
------------

// File: rtl/mac_feeder_if.sv
// Bundles the job handshake, the shared operand-memory read port, the MAC
// drive/return lines and the result handshake of the MAC feeder.
interface mac_feeder_if #(
    parameter int INW   = 16,
    parameter int OUTW  = 48,
    parameter int ADDRW = 3
);
    logic                   start;
    logic                   ready;
    logic                   rd_en;
    logic [ADDRW-1:0]       rd_addr;
    logic signed [INW-1:0]  rd_data_a;
    logic signed [INW-1:0]  rd_data_b;
    logic signed [INW-1:0]  mac_in0;
    logic signed [INW-1:0]  mac_in1;
    logic                   mac_valid;
    logic                   mac_clear;
    logic signed [OUTW-1:0] mac_out;
    logic signed [OUTW-1:0] result;
    logic                   result_valid;
    logic                   result_ready;

    // The feeder side: drives memory reads, MAC operands and the result.
    modport master (
        input  start,
        output ready,
        output rd_en,
        output rd_addr,
        input  rd_data_a,
        input  rd_data_b,
        output mac_in0,
        output mac_in1,
        output mac_valid,
        output mac_clear,
        input  mac_out,
        output result,
        output result_valid,
        input  result_ready
    );

    // The environment side: job requester, operand memories, MAC and consumer.
    modport slave (
        output start,
        input  ready,
        input  rd_en,
        input  rd_addr,
        output rd_data_a,
        output rd_data_b,
        input  mac_in0,
        input  mac_in1,
        input  mac_valid,
        input  mac_clear,
        output mac_out,
        input  result,
        input  result_valid,
        output result_ready
    );
endinterface

// File: rtl/mac_feeder.sv
// MAC feeder: on each accepted job it clears an external MAC, streams K
// operand pairs from two synchronous-read memories into it, then captures
// the MAC's registered accumulator and holds it until the consumer takes it.
module mac_feeder #(
    parameter int INW   = 16,
    parameter int OUTW  = 48,
    parameter int K     = 8,
    parameter int ADDRW = 3
) (
    input  logic         clk,
    input  logic         reset,
    mac_feeder_if.master bus
);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        STREAM,
        WAIT,
        OUT
    } state_t;

    // Index of the final element; when the counter reaches it no further
    // read is issued because all operands are already in flight.
    localparam logic [ADDRW-1:0] LAST_IDX = ADDRW'(K - 1);
    localparam logic signed [INW-1:0] ZERO_IN = '0;

    state_t                 state_q, state_d;
    logic [ADDRW-1:0]       idx_q, idx_d;
    logic signed [OUTW-1:0] result_q, result_d;

    // State, element index and captured result; reset aborts any job at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            result_q <= result_d;
        end
    end

    // Next-state and all outputs decode from the current state only, so a
    // reset forces every output to its idle value without a clock edge.
    always_comb begin
        state_d          = state_q;
        idx_d            = idx_q;
        result_d         = result_q;
        bus.ready        = 1'b0;
        bus.rd_en        = 1'b0;
        bus.rd_addr      = '0;
        bus.mac_in0      = ZERO_IN;
        bus.mac_in1      = ZERO_IN;
        bus.mac_valid    = 1'b0;
        bus.mac_clear    = 1'b0;
        bus.result_valid = 1'b0;

        case (state_q)
            IDLE: begin
                bus.ready = 1'b1;
                if (bus.start) begin
                    state_d = CLEAR;
                end
            end
            CLEAR: begin
                bus.mac_clear = 1'b1;
                bus.rd_en     = 1'b1;
                bus.rd_addr   = '0;
                idx_d         = '0;
                state_d       = STREAM;
            end
            STREAM: begin
                bus.mac_in0   = bus.rd_data_a;
                bus.mac_in1   = bus.rd_data_b;
                bus.mac_valid = 1'b1;
                if (idx_q == LAST_IDX) begin
                    idx_d   = '0;
                    state_d = WAIT;
                end else begin
                    bus.rd_en   = 1'b1;
                    bus.rd_addr = idx_q + ADDRW'(1);
                    idx_d       = idx_q + ADDRW'(1);
                end
            end
            WAIT: begin
                result_d = bus.mac_out;
                state_d  = OUT;
            end
            OUT: begin
                bus.result_valid = 1'b1;
                if (bus.result_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
            end
        endcase
    end

    assign bus.result = result_q;

endmodule

// File: tb/tb_mac_feeder.sv
// Directed bench for mac_feeder: three instances (K=4, K=8, K=1), each with
// its own operand memories and a behavioural registered MAC.
module tb_mac_feeder;

    localparam int INW   = 16;
    localparam int OUTW  = 48;
    localparam int ADDRW = 3;

    logic clk = 1'b0;
    logic reset;
    logic [2:0] startV;
    logic [2:0] resultReadyV;
    logic signed [INW-1:0] memA [3][8];
    logic signed [INW-1:0] memB [3][8];

    wire [2:0] readyW;
    wire [2:0] rdEnW;
    wire [2:0] macValidW;
    wire [2:0] macClearW;
    wire [2:0] resultValidW;
    wire [ADDRW-1:0] rdAddrW [3];
    wire signed [INW-1:0] macIn0W [3];
    wire signed [INW-1:0] macIn1W [3];
    wire signed [OUTW-1:0] resultW [3];

    int checks = 0;
    int errors = 0;

    // Free-running clock, 10 time-unit period.
    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int KV = (g == 0) ? 4 : ((g == 1) ? 8 : 1);

        mac_feeder_if #(.INW(INW), .OUTW(OUTW), .ADDRW(ADDRW)) ifc ();

        logic signed [INW-1:0]  rdA;
        logic signed [INW-1:0]  rdB;
        logic signed [OUTW-1:0] acc = '0;
        logic signed [OUTW-1:0] prod;

        mac_feeder #(.INW(INW), .OUTW(OUTW), .K(KV), .ADDRW(ADDRW)) dut (
            .clk  (clk),
            .reset(reset),
            .bus  (ifc)
        );

        assign ifc.start        = startV[g];
        assign ifc.result_ready = resultReadyV[g];
        assign ifc.rd_data_a    = rdA;
        assign ifc.rd_data_b    = rdB;
        assign ifc.mac_out      = acc;
        assign prod = OUTW'(ifc.mac_in0) * OUTW'(ifc.mac_in1);

        // Synchronous-read operand memories: data valid the cycle after rd_en.
        always @(posedge clk) begin
            if (ifc.rd_en) begin
                rdA <= memA[g][ifc.rd_addr];
                rdB <= memB[g][ifc.rd_addr];
            end
        end

        // Registered MAC: clear wins over accumulate.
        always @(posedge clk) begin
            if (ifc.mac_clear) acc <= '0;
            else if (ifc.mac_valid) acc <= acc + prod;
        end

        assign readyW[g]       = ifc.ready;
        assign rdEnW[g]        = ifc.rd_en;
        assign macValidW[g]    = ifc.mac_valid;
        assign macClearW[g]    = ifc.mac_clear;
        assign resultValidW[g] = ifc.result_valid;
        assign rdAddrW[g]      = ifc.rd_addr;
        assign macIn0W[g]      = ifc.mac_in0;
        assign macIn1W[g]      = ifc.mac_in1;
        assign resultW[g]      = ifc.result;
    end

    task automatic checkOutput(input string tag, input logic signed [63:0] observed,
                               input logic signed [63:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic loadPair(input int g, input int i, input int a, input int b);
        memA[g][i] = INW'(a);
        memB[g][i] = INW'(b);
    endtask

    // Runs one job starting at a negedge with the DUT in IDLE and returns at
    // the negedge of the IDLE cycle that follows OUT.
    task automatic runJob(input int g, input int k, input longint expRes,
                          input longint prevRes, input int hold, input bit pulse);
        int cycle;
        int valids;
        int clears;
        int rdens;
        int firstValid;
        int clearCycle;
        int rvCycle;
        int outCycles;
        bit done;
        resultReadyV[g] = (hold == 0);
        checkOutput("idle ready", readyW[g], 1);
        startV[g] = 1'b1;
        @(negedge clk);
        startV[g]  = 1'b0;
        cycle      = 1;
        valids     = 0;
        clears     = 0;
        rdens      = 0;
        firstValid = -1;
        clearCycle = -1;
        rvCycle    = -1;
        outCycles  = 0;
        done       = 1'b0;
        while (!done && cycle < 40) begin
            if (macClearW[g]) begin
                clears++;
                if (clearCycle < 0) clearCycle = cycle;
            end
            if (macValidW[g]) begin
                valids++;
                if (firstValid < 0) firstValid = cycle;
            end
            if (rdEnW[g]) rdens++;
            if (cycle == 1) begin
                checkOutput("clear rd_addr", rdAddrW[g], 0);
                checkOutput("clear rd_en", rdEnW[g], 1);
            end
            if (cycle == 2) begin
                checkOutput("stream in0", macIn0W[g], memA[g][0]);
                checkOutput("stream in1", macIn1W[g], memB[g][0]);
                checkOutput("stream rd_addr", rdAddrW[g], (k > 1) ? 1 : 0);
            end
            if (cycle == k + 2) checkOutput("wait prev result", resultW[g], prevRes);
            if (resultValidW[g]) begin
                if (rvCycle < 0) rvCycle = cycle;
                outCycles++;
                checkOutput("out result", resultW[g], expRes);
                checkOutput("out ready", readyW[g], 0);
                if (hold > 0 && outCycles > hold) resultReadyV[g] = 1'b1;
            end else if (rvCycle >= 0) begin
                done = 1'b1;
            end
            if (!done) begin
                startV[g] = pulse && (cycle == 3 || resultValidW[g]);
                @(negedge clk);
                cycle++;
            end
        end
        startV[g] = 1'b0;
        checkOutput("clear count", clears, 1);
        checkOutput("clear cycle", clearCycle, 1);
        checkOutput("first valid cycle", firstValid, 2);
        checkOutput("valid count", valids, k);
        checkOutput("rd_en count", rdens, k);
        checkOutput("result_valid cycle", rvCycle, k + 3);
        checkOutput("out length", outCycles, (hold > 0) ? hold + 1 : 1);
        checkOutput("back to idle", readyW[g], 1);
        checkOutput("result held", resultW[g], expRes);
    endtask

    initial begin
        int extraClears;
        reset        = 1'b1;
        startV       = '0;
        resultReadyV = '1;
        #1;
        checkOutput("reset ready", readyW[0], 1);
        checkOutput("reset result", resultW[0], 0);
        checkOutput("reset result_valid", resultValidW[0], 0);
        checkOutput("reset rd_en", rdEnW[0], 0);
        @(negedge clk);
        reset = 1'b0;

        // Positive dot product, consumer always ready.
        for (int i = 0; i < 4; i++) loadPair(0, i, i + 1, i + 5);
        runJob(0, 4, 70, 0, 0, 1'b0);

        // Mixed-sign operands with a stalled consumer.
        loadPair(0, 0, -3, 4);
        loadPair(0, 1, 0, 9);
        loadPair(0, 2, 2, -5);
        loadPair(0, 3, -1, -6);
        runJob(0, 4, -16, 70, 5, 1'b0);

        // Start pulses during STREAM and OUT must not launch a second job.
        for (int i = 0; i < 4; i++) loadPair(0, i, i + 1, i + 5);
        runJob(0, 4, 70, -16, 0, 1'b1);
        extraClears = 0;
        for (int i = 0; i < 5; i++) begin
            if (macClearW[0]) extraClears++;
            @(negedge clk);
        end
        checkOutput("no extra clear", extraClears, 0);
        checkOutput("still idle", readyW[0], 1);

        // Reset in STREAM element 2, then a fresh job right after release.
        loadPair(0, 0, -3, 4);
        loadPair(0, 1, 0, 9);
        loadPair(0, 2, 2, -5);
        loadPair(0, 3, -1, -6);
        startV[0] = 1'b1;
        @(negedge clk);
        startV[0] = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("mid stream valid", macValidW[0], 1);
        reset = 1'b1;
        #1;
        checkOutput("abort ready", readyW[0], 1);
        checkOutput("abort result", resultW[0], 0);
        checkOutput("abort result_valid", resultValidW[0], 0);
        checkOutput("abort rd_en", rdEnW[0], 0);
        checkOutput("abort rd_addr", rdAddrW[0], 0);
        checkOutput("abort in0", macIn0W[0], 0);
        checkOutput("abort in1", macIn1W[0], 0);
        checkOutput("abort mac_valid", macValidW[0], 0);
        checkOutput("abort mac_clear", macClearW[0], 0);
        @(negedge clk);
        reset = 1'b0;
        runJob(0, 4, -16, 0, 0, 1'b0);

        // Back-to-back K=8 jobs with no idle gap beyond the single IDLE cycle.
        for (int i = 0; i < 8; i++) loadPair(1, i, 1, 1);
        runJob(1, 8, 8, 0, 0, 1'b0);
        for (int i = 0; i < 8; i++) loadPair(1, i, 2, 3);
        runJob(1, 8, 48, 8, 0, 1'b0);

        // Single-element vector at the most negative operand value.
        loadPair(2, 0, -32768, -32768);
        runJob(2, 1, 1073741824, 0, 0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
